dma_bus_arbiter: RTL and testbench

- Owns the single memory port in front of the sm83 core and shares it between the CPU and a Game Boy–style OAM DMA engine.
- A CPU write to the DMA register starts a copy of DMA_LEN bytes from {V,8'h00} to OAM_BASE.
- While the copy runs, the CPU is locked out of the memory port and keeps access only to internal HRAM and the DMA register.
- Sits between the sm83 bus (addr/d_in/d_out/write) and the memory model.

---
 rtl/dma_pkg.sv | 15 +
 rtl/hram.sv | 21 ++
 rtl/dma_bus_arbiter.sv | 134 +++++++++++++
 tb/tb_dma_bus_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared types and default address map for the OAM DMA bus arbiter.
package dma_pkg;

  typedef enum logic [1:0] {StIdle, StStart, StRead, StWrite} dma_state_e;

  typedef enum logic [1:0] {SelMem, SelHram, SelReg, SelBlocked} rdata_sel_e;

  localparam logic [15:0] DefDmaRegAddr = 16'hFF46;
  localparam logic [15:0] DefOamBase    = 16'hFE00;
  localparam int unsigned DefDmaLen     = 160;
  localparam logic [15:0] DefHramLo     = 16'hFF80;
  localparam logic [15:0] HramHi        = 16'hFFFE;
  localparam int unsigned HramDepth     = 127;

endpackage

// File: rtl/hram.sv
// Internal high RAM: synchronous write, registered read with one cycle of latency.
module hram
  import dma_pkg::*;
(
  input  logic       clk,
  input  logic       we,
  input  logic [6:0] a,
  input  logic [7:0] d,
  output logic [7:0] q
);

  logic [7:0] mem [HramDepth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[a] <= d;
    end
    q <= mem[a];
  end

endmodule

// File: rtl/dma_bus_arbiter.sv
// Shares the single memory port between the CPU and the OAM DMA engine; the CPU keeps
// HRAM and the DMA register while a copy is running.
module dma_bus_arbiter
  import dma_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR = DefDmaRegAddr,
  parameter logic [15:0] OAM_BASE     = DefOamBase,
  parameter int unsigned DMA_LEN      = DefDmaLen,
  parameter logic [15:0] HRAM_LO      = DefHramLo
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_write,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_write,
  input  logic [7:0]  mem_rdata,
  output logic        dma_active
);

  localparam int unsigned IdxW = $clog2(DMA_LEN);

  dma_state_e     state_q, state_d;
  rdata_sel_e     sel_q, sel_d;
  logic [IdxW-1:0] index_q, index_d;
  logic [7:0]     src_q, src_d;
  logic           active_q, active_d;
  logic [7:0]     hram_q;

  logic is_reg, is_hram, is_mem, dma_owns, reg_write;

  assign is_reg    = (cpu_addr == DMA_REG_ADDR);
  assign is_hram   = (cpu_addr >= HRAM_LO) && (cpu_addr <= HramHi);
  assign is_mem    = !is_reg && !is_hram;
  assign dma_owns  = (state_q == StRead) || (state_q == StWrite);
  assign reg_write = cpu_write && is_reg;

  hram u_hram (
    .clk (clk),
    .we  (cpu_write && is_hram),
    .a   (7'(cpu_addr - HRAM_LO)),
    .d   (cpu_wdata),
    .q   (hram_q)
  );

  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    src_d    = src_q;
    active_d = active_q;
    unique case (state_q)
      StIdle: ;
      StStart: begin
        state_d  = StRead;
        active_d = 1'b1;
      end
      StRead:  state_d = StWrite;
      StWrite: begin
        if (index_q == IdxW'(DMA_LEN - 1)) begin
          state_d  = StIdle;
          active_d = 1'b0;
          index_d  = '0;
        end else begin
          index_d = index_q + IdxW'(1);
          state_d = StRead;
        end
      end
      default: state_d = StIdle;
    endcase
    // A register write restarts the copy; the port cycle in flight still completes.
    if (reg_write) begin
      src_d   = cpu_wdata;
      state_d = StStart;
      index_d = '0;
    end
  end

  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_write = cpu_write && is_mem;
    unique case (state_q)
      StRead: begin
        mem_addr  = {src_q, 8'(index_q)};
        mem_wdata = '0;
        mem_write = 1'b0;
      end
      StWrite: begin
        mem_addr  = OAM_BASE + 16'(index_q);
        mem_wdata = mem_rdata;
        mem_write = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    if (is_reg)        sel_d = SelReg;
    else if (is_hram)  sel_d = SelHram;
    else if (dma_owns) sel_d = SelBlocked;
    else               sel_d = SelMem;
  end

  always_comb begin
    unique case (sel_q)
      SelMem:  cpu_rdata = mem_rdata;
      SelHram: cpu_rdata = hram_q;
      SelReg:  cpu_rdata = src_q;
      default: cpu_rdata = 8'hFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      index_q  <= '0;
      src_q    <= 8'hFF;
      active_q <= 1'b0;
      sel_q    <= SelMem;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      src_q    <= src_d;
      active_q <= active_d;
      sel_q    <= sel_d;
    end
  end

  assign dma_active = active_q;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Directed bench for dma_bus_arbiter with a behavioural memory and an expectation queue.
module tb_dma_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_write;
  logic [7:0]  cpu_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_write;
  logic [7:0]  mem_rdata;
  logic        dma_active;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dma_bus_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_write  (cpu_write),
    .cpu_rdata  (cpu_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_write  (mem_write),
    .mem_rdata  (mem_rdata),
    .dma_active (dma_active)
  );

  // Page C0 holds i^5A; every other byte holds low^high^33.
  function automatic logic [7:0] init_val(input logic [15:0] a);
    return (a[15:8] == 8'hC0) ? (a[7:0] ^ 8'h5A) : (a[7:0] ^ a[15:8] ^ 8'h33);
  endfunction

  logic [7:0] mem [65536];
  logic       init_done = 1'b0;

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 65536; i++) mem[i] <= init_val(16'(i));
      init_done <= 1'b1;
    end else if (mem_write) begin
      mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr];
  end

  logic [15:0] sb_q[$];
  string       tag_q[$];

  task automatic sb_push(input string tag, input logic [15:0] v);
    sb_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic sb_check(input logic [15:0] obs);
    logic [15:0] exp;
    string       tag;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL sb_underflow: got %h with no expectation queued", obs);
    end else begin
      exp = sb_q.pop_front();
      tag = tag_q.pop_front();
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s: got %h required %h", tag, obs, exp);
      end
    end
  endtask

  // Issues a register write; returns at the negedge after the write edge (state START).
  task automatic start_dma(input logic [7:0] v);
    cpu_addr  = 16'hFF46;
    cpu_wdata = v;
    cpu_write = 1'b1;
    @(negedge clk);
    cpu_write = 1'b0;
    cpu_addr  = 16'h0100;
  endtask

  initial begin
    int cnt;
    cpu_addr  = 16'h0100;
    cpu_wdata = 8'h00;
    cpu_write = 1'b0;

    // Reset state
    sb_push("rst_active", 16'h0000);
    sb_push("rst_passthru", 16'h0100);
    sb_push("rst_reg_read", 16'h00FF);
    repeat (3) @(negedge clk);
    sb_check(16'(dma_active));
    sb_check(mem_addr);
    cpu_addr = 16'hFF46;
    rst      = 1'b1;
    @(negedge clk);
    sb_check(16'(cpu_rdata));
    cpu_addr = 16'h0100;
    @(negedge clk);

    // Full transfer from C000 with lockout and HRAM traffic mid-copy
    sb_push("start_active", 16'h0000);
    sb_push("start_passthru", 16'h0100);
    sb_push("lock_read", 16'h00FF);
    for (int i = 0; i < 3; i++) sb_push("lock_port", 16'h0001);
    sb_push("hram_read", 16'h003C);
    sb_push("active_cycles", 16'd320);
    sb_push("idle_active", 16'h0000);
    sb_push("idle_passthru", 16'h0100);
    sb_push("lock_write", 16'(init_val(16'hC100)));
    for (int i = 0; i < 160; i++) sb_push("oam_c0", 16'(8'(i) ^ 8'h5A));
    start_dma(8'hC0);
    #1;
    sb_check(16'(dma_active));
    sb_check(mem_addr);
    cnt = 0;
    for (int k = 1; k <= 321; k++) begin
      @(negedge clk);
      if (dma_active) cnt++;
      if (k == 11 || k == 14) sb_check(16'(cpu_rdata));
      case (k)
        10: cpu_addr = 16'hC000;
        11: begin cpu_addr = 16'hC100; cpu_wdata = 8'h77; cpu_write = 1'b1; end
        12: begin cpu_addr = 16'hFF90; cpu_wdata = 8'h3C; cpu_write = 1'b1; end
        13: begin cpu_addr = 16'hFF90; cpu_write = 1'b0; end
        15: cpu_addr = 16'h0100;
        default: ;
      endcase
      if (k >= 11 && k <= 13) begin
        #1;
        sb_check(16'((mem_addr[15:8] == 8'hC0) || (mem_addr[15:8] == 8'hFE)));
      end
    end
    sb_check(16'(cnt));
    sb_check(16'(dma_active));
    sb_check(mem_addr);
    sb_check(16'(mem[16'hC100]));
    for (int i = 0; i < 160; i++) sb_check(16'(mem[16'hFE00 + i]));

    // Restart to D000 while the WRITE of index 50 is on the port
    sb_push("collide_write", 16'h0001);
    sb_push("collide_addr", 16'hFE32);
    sb_push("restart_addr", 16'hD000);
    sb_push("restart_cycles", 16'd321);
    sb_push("restart_idle", 16'h0000);
    for (int i = 0; i < 160; i++) sb_push("oam_d0", 16'(8'(i) ^ 8'hE3));
    start_dma(8'hC0);
    for (int k = 1; k <= 102; k++) @(negedge clk);
    cpu_addr  = 16'hFF46;
    cpu_wdata = 8'hD0;
    cpu_write = 1'b1;
    #1;
    sb_check(16'(mem_write));
    sb_check(mem_addr);
    @(negedge clk);
    cpu_write = 1'b0;
    cpu_addr  = 16'h0100;
    cnt = dma_active ? 1 : 0;
    for (int j = 1; j <= 321; j++) begin
      @(negedge clk);
      if (j == 1) sb_check(mem_addr);
      if (dma_active) cnt++;
    end
    sb_check(16'(cnt));
    sb_check(16'(dma_active));
    for (int i = 0; i < 160; i++) sb_check(16'(mem[16'hFE00 + i]));

    // Asynchronous reset at index 80
    sb_push("abort_active", 16'h0000);
    sb_push("abort_reg", 16'h00FF);
    sb_push("abort_writes", 16'h0000);
    for (int i = 0; i < 80; i++) sb_push("abort_lo", 16'(8'(i) ^ 8'h5A));
    for (int i = 80; i < 160; i++) sb_push("abort_hi", 16'(8'(i) ^ 8'hE3));
    start_dma(8'hC0);
    for (int k = 1; k <= 161; k++) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    sb_check(16'(dma_active));
    @(negedge clk);
    @(negedge clk);
    cpu_addr = 16'hFF46;
    rst      = 1'b1;
    cnt      = 0;
    for (int j = 0; j < 400; j++) begin
      @(negedge clk);
      if (j == 0) sb_check(16'(cpu_rdata));
      if (mem_write) cnt++;
    end
    sb_check(16'(cnt));
    for (int i = 0; i < 160; i++) sb_check(16'(mem[16'hFE00 + i]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
